// File: rtl/xorshift_pkg.sv
// ----------------------------------------------------------------------------
// xorshift_pkg
// Constants shared by the 32-bit xorshift generator and its step function:
//   STATE_W        : width of the generator state (32)
//   DEF_SHIFT_A/B/C: default Marsaglia shift triple (13, 17, 5)
//   DEF_RST_VAL    : default state loaded by reset
//   ZERO_SUBST     : value stored instead of 0 when the zero guard is built in
// ----------------------------------------------------------------------------
package xorshift_pkg;

    localparam int unsigned STATE_W     = 32;

    localparam int unsigned DEF_SHIFT_A = 13;
    localparam int unsigned DEF_SHIFT_B = 17;
    localparam int unsigned DEF_SHIFT_C = 5;

    localparam logic [STATE_W-1:0] DEF_RST_VAL = 32'h0000_0000;
    localparam logic [STATE_W-1:0] ZERO_SUBST  = 32'h0000_0001;

endpackage : xorshift_pkg

// File: rtl/xorshift32_step.sv
// ----------------------------------------------------------------------------
// xorshift32_step
// Purely combinational single Marsaglia xorshift step:
//   t1 = x ^ (x << SHIFT_A); t2 = t1 ^ (t1 >> SHIFT_B); f = t2 ^ (t2 << SHIFT_C)
// All shifts are logical and truncated to the state width.
// Ports:
//   i_x : current state
//   o_f : next state f(i_x)
// ----------------------------------------------------------------------------
module xorshift32_step
    import xorshift_pkg::*;
#(
    parameter int unsigned SHIFT_A = DEF_SHIFT_A,
    parameter int unsigned SHIFT_B = DEF_SHIFT_B,
    parameter int unsigned SHIFT_C = DEF_SHIFT_C
) (
    input  logic [STATE_W-1:0] i_x,
    output logic [STATE_W-1:0] o_f
);

    logic [STATE_W-1:0] w_t1;
    logic [STATE_W-1:0] w_t2;

    assign w_t1 = i_x  ^ (i_x  << SHIFT_A);
    assign w_t2 = w_t1 ^ (w_t1 >> SHIFT_B);
    assign o_f  = w_t2 ^ (w_t2 << SHIFT_C);

endmodule : xorshift32_step

// File: rtl/xor_shift32_opt.sv
// ----------------------------------------------------------------------------
// xor_shift32_opt
// 32-bit xorshift pseudo-random generator. The state register advances by one
// xorshift step per clock; a seed can be loaded synchronously, and the
// registered state is the random output.
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst     : asynchronous active-high reset, loads RST_VAL
//   seed    : value loaded into the state while re_seed is high
//   re_seed : synchronous, level-sensitive load strobe (beats advance)
//   rnd     : current state (registered)
// Build option:
//   XORSHIFT32_ZERO_GUARD_EN : when defined, any all-zero load (seed or
//   RST_VAL) stores 32'h1 instead, so the generator cannot lock at 0.
// ----------------------------------------------------------------------------
module xor_shift32_opt
    import xorshift_pkg::*;
#(
    parameter int unsigned        SHIFT_A = DEF_SHIFT_A,
    parameter int unsigned        SHIFT_B = DEF_SHIFT_B,
    parameter int unsigned        SHIFT_C = DEF_SHIFT_C,
    parameter logic [STATE_W-1:0] RST_VAL = DEF_RST_VAL
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] seed,
    input  logic               re_seed,
    output logic [STATE_W-1:0] rnd
);

    // Applied to loaded values only: f is a bijection with 0 as its only
    // fixed point, so a nonzero state never steps into 0.
    function automatic logic [STATE_W-1:0] load_guard(input logic [STATE_W-1:0] v);
`ifdef XORSHIFT32_ZERO_GUARD_EN
        return (v == '0) ? ZERO_SUBST : v;
`else
        return v;
`endif
    endfunction

    localparam logic [STATE_W-1:0] RST_LOAD = load_guard(RST_VAL);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_next;
    logic [STATE_W-1:0] w_seed_ld;

    xorshift32_step #(
        .SHIFT_A (SHIFT_A),
        .SHIFT_B (SHIFT_B),
        .SHIFT_C (SHIFT_C)
    ) u_step (
        .i_x (r_state),
        .o_f (w_next)
    );

    assign w_seed_ld = load_guard(seed);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= RST_LOAD;
        end else if (re_seed) begin
            r_state <= w_seed_ld;
        end else begin
            r_state <= w_next;
        end
    end

    assign rnd = r_state;

endmodule : xor_shift32_opt

// File: tb/tb_xor_shift32_opt.sv
module tb_xor_shift32_opt;

    localparam logic [31:0] RST_VAL = 32'h0000_0000;

    logic        clk;
    logic        rst;
    logic [31:0] seed;
    logic        re_seed;
    logic [31:0] rnd;

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_s;

    xor_shift32_opt #(
        .SHIFT_A (13),
        .SHIFT_B (17),
        .SHIFT_C (5),
        .RST_VAL (RST_VAL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .seed    (seed),
        .re_seed (re_seed),
        .rnd     (rnd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference step written as arithmetic: left shift = multiply by 2^k
    // modulo 2^32, right shift = integer division by 2^k.
    function automatic logic [31:0] model_f(input logic [31:0] x);
        longint unsigned m, v, t;
        m = 64'd1 << 32;
        v = 64'(x);
        t = (v ^ ((v * (64'd1 << 13)) % m));
        t = (t ^ (t / (64'd1 << 17)));
        t = (t ^ ((t * (64'd1 << 5)) % m));
        return 32'(t);
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] v);
`ifdef XORSHIFT32_ZERO_GUARD_EN
        if (v == 32'd0) return 32'd1;
`endif
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] expv);
        checks++;
        assert (rnd === expv) else begin
            errors++;
            $error("FAIL %s: rnd=%h expected=%h", tag, rnd, expv);
        end
    endtask

    // One rising edge: predict next state from the inputs in force, then
    // compare 1 time unit after the edge.
    task automatic tick(input string tag);
        logic [31:0] nxt;
        if (rst)          nxt = model_load(RST_VAL);
        else if (re_seed) nxt = model_load(seed);
        else              nxt = model_f(exp_s);
        @(posedge clk);
        #1;
        exp_s = nxt;
        check(tag, exp_s);
    endtask

    initial begin
        rst     = 1'b0;
        seed    = 32'd0;
        re_seed = 1'b0;
        #2;
        // Asynchronous reset visible before any clock edge
        rst = 1'b1;
        #1;
        exp_s = model_load(RST_VAL);
        check("reset_async", exp_s);
        tick("reset_hold");
        rst = 1'b0;

        // Free run after reset
        for (int i = 0; i < 5; i++) begin
            tick("post_reset_run");
`ifndef XORSHIFT32_ZERO_GUARD_EN
            check("post_reset_zero", 32'h0);
`endif
        end

        // Reseed DEADBEEF, then two advances (known values)
        seed = 32'hDEADBEEF; re_seed = 1'b1;
        tick("seed_dead");
        check("seed_dead_const", 32'hDEADBEEF);
        re_seed = 1'b0;
        tick("dead_f1");
        check("dead_f1_const", 32'h477D20B7);
        tick("dead_f2");
        check("dead_f2_const", 32'h8E1D9142);

        // Reseed 1
        seed = 32'h1; re_seed = 1'b1;
        tick("seed_one");
        re_seed = 1'b0;
        tick("one_f1");
        check("one_f1_const", 32'h00042021);

        // Hold re_seed for 3 edges
        seed = 32'hCAFEBABE; re_seed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick("hold_seed");
            check("hold_seed_const", 32'hCAFEBABE);
        end
        re_seed = 1'b0;
        tick("cafe_f1");

        // Seed changes while held: last sampled value wins
        re_seed = 1'b1;
        seed = 32'h1234_5678; tick("hold_chg_a");
        seed = 32'h8765_4321; tick("hold_chg_b");
        re_seed = 1'b0;
        tick("hold_chg_adv");

        // Async reset between edges
        tick("pre_rst_adv");
        @(negedge clk);
        rst = 1'b1;
        #1;
        exp_s = model_load(RST_VAL);
        check("mid_rst_async", exp_s);
        seed = 32'hA5A5_A5A5; re_seed = 1'b1;
        tick("rst_beats_reseed");
        tick("rst_beats_reseed2");
        // First edge with rst low applies re_seed
        rst = 1'b0;
        tick("post_rst_reseed");
        re_seed = 1'b0;
        tick("post_rst_adv");

        // Zero seed
        seed = 32'h0; re_seed = 1'b1;
        tick("seed_zero");
        re_seed = 1'b0;
        tick("zero_f1");
`ifdef XORSHIFT32_ZERO_GUARD_EN
        check("zero_f1_guard", 32'h00042021);
`else
        check("zero_f1_const", 32'h0);
`endif
        tick("zero_f2");

        // Randomized reseed / advance traffic against the model
        for (int i = 0; i < 300; i++) begin
            re_seed = ($urandom_range(0, 7) == 0);
            seed    = ($urandom_range(0, 15) == 0) ? 32'h0 : $urandom;
            tick("random");
        end
        re_seed = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global timeout guard
    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule : tb_xor_shift32_opt
